// File: rtl/coeff_loader.sv
// Coefficient loader: accepts LENGTH signed words into a tap table read by the FIR datapath.
// Optional running checksum of the current load is enabled with `define COEFF_CHECKSUM_EN.
module coeff_loader #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 6,
    localparam int ADDRESS_BIT = $clog2(LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_BIT-1:0]   address,
    output logic signed [WIDTH-1:0]  out_put,
    output logic                     busy,
    output logic                     load_done,
    output logic [ADDRESS_BIT:0]     wr_count
`ifdef COEFF_CHECKSUM_EN
    ,
    output logic signed [WIDTH+ADDRESS_BIT:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDRESS_BIT:0] LAST_INDEX = (ADDRESS_BIT+1)'(LENGTH - 1);
    localparam logic [ADDRESS_BIT:0] SLOT_COUNT = (ADDRESS_BIT+1)'(LENGTH);

    state_t                  state;
    state_t                  next_state;
    logic signed [WIDTH-1:0] data [LENGTH];
    logic                    handshake;
    logic                    start_load;

    assign handshake = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // start is deliberately ignored here; only the last handshake leaves LOAD
                if (in_valid && (wr_count == LAST_INDEX)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (start) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (start_load) begin
            wr_count <= '0;
        end else if (handshake) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Slots not yet rewritten in a reload keep their old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LENGTH; i++) begin
                data[i] <= '0;
            end
        end else if (handshake) begin
            data[wr_count[ADDRESS_BIT-1:0]] <= in_data;
        end
    end

    always_comb begin
        out_put = '0;
        if ({1'b0, address} < SLOT_COUNT) begin
            out_put = data[address];
        end
    end

`ifdef COEFF_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_load) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum + {{(ADDRESS_BIT+1){in_data[WIDTH-1]}}, in_data};
        end
    end
`endif

endmodule
